// File: rtl/rv32i_lsu_pkg.sv
// Shared definitions for the RV32I load/store data port: funct3 codes,
// FSM state encoding, timeout default and request legality helpers.
package rv32i_lsu_pkg;

    localparam int unsigned MAX_WAIT_DEFAULT = 16;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 inside {F3_SB, F3_SH, F3_SW};
        end
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    // Access size lives in funct3[1:0] for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: selects the addressed byte/half from the
// returned word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import rv32i_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] load_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   load_data_c = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data_c = {24'h000000, byte_sel};
            F3_LH:   load_data_c = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data_c = {16'h0000, half_sel};
            default: load_data_c = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_data_port.sv
// RV32I LSU data port: accepts one access at a time, drives a req/gnt memory
// port and returns a one-cycle response. Define LSU_MISALIGN_CHECK_EN to flag
// misaligned half/word accesses as errors.
module lsu_data_port
    import rv32i_lsu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        misalign_c;
    logic [31:0] load_data_c;

    lsu_load_align u_load_align (
        .funct3      (funct3_q),
        .addr_lo     (addr_lo_q),
        .rdata       (mem_rdata),
        .load_data_c (load_data_c)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign_c = misaligned(req_funct3, req_addr[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    // Store lane steering from the incoming request.
    always_comb begin
        be_c    = 4'b0000;
        wdata_c = req_wdata;
        case (req_funct3)
            F3_SB: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            F3_SH: begin
                be_c    = 4'b0011 << {req_addr[1], 1'b0};
                wdata_c = {2{req_wdata[15:0]}};
            end
            F3_SW: begin
                be_c    = 4'b1111;
                wdata_c = req_wdata;
            end
            default: begin
                be_c    = 4'b0000;
                wdata_c = req_wdata;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    funct3_d   = req_funct3;
                    addr_lo_d  = req_addr[1:0];
                    rsp_data_d = 32'h0000_0000;
                    cnt_d      = '0;
                    if (!funct3_legal(req_we, req_funct3) || misalign_c) begin
                        rsp_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        rsp_err_d   = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_be_d    = req_we ? be_c : 4'b0000;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = wdata_c;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                    cnt_d     = '0;
                    state_d   = we_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // rvalid on the final allowed cycle still wins over timeout.
                if (mem_rvalid) begin
                    rsp_data_d = load_data_c;
                    state_d    = ST_DONE;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    rsp_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'h0000_0000;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Directed bench for lsu_data_port: reset, stores, load extraction, stalls,
// illegal funct3, misalignment, timeout and reset abort.
module tb_lsu_data_port;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    // Load table: funct3, address, expected result for rdata 0x80FF1234.
    logic [2:0]  ld_f3   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010, 3'b001};
    logic [31:0] ld_addr [7] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h201, 32'h200, 32'h200};
    logic [31:0] ld_exp  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                 32'h0000_0012, 32'h80FF_1234, 32'h0000_1234};
    logic [3:0]  sb_be   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic        il_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  il_f3   [4] = '{3'b011, 3'b100, 3'b110, 3'b111};

    always #5 clk = ~clk;

    lsu_data_port #(.MAX_WAIT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one request for the transfer edge, then scramble the inputs.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
        req_we     = ~we;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5555_5555;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, mem_be, rsp_valid, rsp_err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b be=%b vld=%b err=%b want all 0",
                     mem_req, mem_we, mem_be, rsp_valid, rsp_err);
        end
        checks++;
        if (rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp_data: got %h want 00000000", rsp_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_store_word();
        mem_gnt = 1'b1;
        issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        checks++;
        if ({mem_req, mem_we, mem_be, rsp_valid, req_ready} !== 8'b1_1_1111_0_0) begin
            errors++;
            $display("FAIL sw_req: got req=%b we=%b be=%b vld=%b rdy=%b want 1 1 1111 0 0",
                     mem_req, mem_we, mem_be, rsp_valid, req_ready);
        end
        checks++;
        if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_addr_data: got %h/%h want 00000100/deadbeef", mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_err, mem_req} !== 3'b100 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL sw_rsp: got vld=%b err=%b req=%b data=%h want 1 0 0 00000000",
                     rsp_valid, rsp_err, mem_req, rsp_data);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL sw_pulse_end: got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
        end
        mem_gnt = 1'b0;
    endtask

    task automatic test_load_extract();
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF_1234;
        for (int i = 0; i < 7; i++) begin
            logic [31:0] want_addr;
            want_addr = {ld_addr[i][31:2], 2'b00};
            issue(1'b0, ld_f3[i], ld_addr[i], 32'h0);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== want_addr) begin
                errors++;
                $display("FAIL load%0d_req: got req=%b we=%b addr=%h want 1 0 %h",
                         i, mem_req, mem_we, mem_addr, want_addr);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL load%0d_early: got vld=%b want 0", i, rsp_valid);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== ld_exp[i]) begin
                errors++;
                $display("FAIL load%0d_rsp: got vld=%b err=%b data=%h want 1 0 %h",
                         i, rsp_valid, rsp_err, rsp_data, ld_exp[i]);
            end
            tick();
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_half_stall();
        mem_gnt = 1'b0;
        issue(1'b1, 3'b001, 32'h102, 32'h0000_ABCD);
        // Competing request while busy must not be taken.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h777;
        req_wdata  = 32'h0BAD_0BAD;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({mem_req, mem_we, mem_be, rsp_valid} !== 7'b1_1_1100_0 ||
                mem_addr !== 32'h100 || mem_wdata !== 32'hABCD_ABCD) begin
                errors++;
                $display("FAIL sh_stall%0d: got req=%b we=%b be=%b vld=%b addr=%h wd=%h want 1 1 1100 0 00000100 abcdabcd",
                         i, mem_req, mem_we, mem_be, rsp_valid, mem_addr, mem_wdata);
            end
            if (i < 3) tick();
        end
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL sh_done: got vld=%b err=%b req=%b want 1 0 0", rsp_valid, rsp_err, mem_req);
        end
        tick();
        mem_gnt = 1'b0;
    endtask

    task automatic test_byte_lanes();
        mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 3'b000, 32'h400 + 32'(i), 32'h1234_56A5);
            checks++;
            if (mem_be !== sb_be[i] || mem_wdata !== 32'hA5A5_A5A5 || mem_addr !== 32'h400) begin
                errors++;
                $display("FAIL sb_lane%0d: got be=%b wd=%h addr=%h want %b a5a5a5a5 00000400",
                         i, mem_be, mem_wdata, mem_addr, sb_be[i]);
            end
            tick();
            tick();
        end
        mem_gnt = 1'b0;
    endtask

    task automatic test_illegal_funct3();
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            issue(il_we[i], il_f3[i], 32'h500, 32'hFFFF_0000);
            checks++;
            if ({rsp_valid, rsp_err, mem_req} !== 3'b110 || rsp_data !== 32'h0) begin
                errors++;
                $display("FAIL illegal%0d: got vld=%b err=%b req=%b data=%h want 1 1 0 00000000",
                         i, rsp_valid, rsp_err, mem_req, rsp_data);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL illegal%0d_after: got vld=%b req=%b want 0 0", i, rsp_valid, mem_req);
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_misalign();
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1122_3344;
        issue(1'b0, 3'b010, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        checks++;
        if ({rsp_valid, rsp_err, mem_req} !== 3'b110 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL lw_misalign_err: got vld=%b err=%b req=%b data=%h want 1 1 0 00000000",
                     rsp_valid, rsp_err, mem_req, rsp_data);
        end
        tick();
        checks++;
        if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL lw_misalign_after: got req=%b vld=%b want 0 0", mem_req, rsp_valid);
        end
`else
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL lw_unaligned_req: got req=%b addr=%h want 1 00000100", mem_req, mem_addr);
        end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'h1122_3344) begin
            errors++;
            $display("FAIL lw_unaligned_rsp: got vld=%b err=%b data=%h want 1 0 11223344",
                     rsp_valid, rsp_err, rsp_data);
        end
        tick();
`endif
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_timeout_and_reset();
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        issue(1'b0, 3'b001, 32'h600, 32'h0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: got vld=%b rdy=%b want 0 0", i, rsp_valid, req_ready);
            end
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL timeout_rsp: got vld=%b err=%b data=%h want 1 1 00000000",
                     rsp_valid, rsp_err, rsp_data);
        end
        tick();

        issue(1'b0, 3'b010, 32'h700, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got rdy=%b vld=%b req=%b want 1 0 0", req_ready, rsp_valid, mem_req);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL stray_rvalid%0d: got vld=%b data=%h rdy=%b want 0 00000000 1",
                         i, rsp_valid, rsp_data, req_ready);
            end
        end
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_store_word();
        test_load_extract();
        test_half_stall();
        test_byte_lanes();
        test_illegal_funct3();
        test_misalign();
        test_timeout_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
